// File: rtl/timer_pulse_gen.sv
// timer_pulse_gen
// Master timepulse sequencer plus free-running scaler drive.
// One memory cycle (MCT) is 24 CLOCK cycles: T01..T12, two cycles each,
// PHS2 marks the first and PHS4 the second cycle of every timepulse.
// STOP parks the sequencer at the end of the current MCT; STEP (when built)
// runs one MCT from the parked state.
//
// Build option: define TIMER_STEP_EN to build the STEP synchronizer and the
// STEP1 state. Without it the STEP port is present but has no effect.
//
// Parameters:
//   GATE_DELAY - simulation-only output delay annotation, no functional effect
//   DIV_FS01   - FS01_ full period in CLOCK cycles (even, >= 2)
// Ports:
//   CLOCK   in  master clock, rising-edge
//   rst     in  asynchronous active-low reset
//   STOP    in  asynchronous stop request (synchronized here)
//   STEP    in  asynchronous single-MCT step request (synchronized here)
//   FS01_   out active-low scaler drive, 50% duty, period DIV_FS01
//   T01..T12 out one-hot (or all-low) timepulses
//   PHS2    out first cycle of a timepulse
//   PHS4    out second cycle of a timepulse
//   MCT     out one-cycle pulse in the last cycle of T12
//   STOPPED out high while parked
module timer_pulse_gen #(
  parameter int GATE_DELAY = 0,
  parameter int DIV_FS01   = 20
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic STOP,
  input  logic STEP,
  output logic FS01_,
  output logic T01,
  output logic T02,
  output logic T03,
  output logic T04,
  output logic T05,
  output logic T06,
  output logic T07,
  output logic T08,
  output logic T09,
  output logic T10,
  output logic T11,
  output logic T12,
  output logic PHS2,
  output logic PHS4,
  output logic MCT,
  output logic STOPPED
);

  localparam int HALF = DIV_FS01 / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW-1:0] DIV_TC  = DW'(HALF - 1);
  localparam logic [4:0]    LAST_POS = 5'd23;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PARK  = 2'd1,
    ST_STEP1 = 2'd2
  } state_t;

  // The delay parameter only annotates simulation timing; keep it referenced.
  logic unused_gate_s;
  assign unused_gate_s = (GATE_DELAY != 0);

  // ---------------------------------------------------------------- inputs
  logic stop_m_r, stop_s_r;
  logic step_rise_s;

  // Two-flop synchronizer for STOP.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      stop_m_r <= 1'b0;
      stop_s_r <= 1'b0;
    end else begin
      stop_m_r <= STOP;
      stop_s_r <= stop_m_r;
    end
  end

`ifdef TIMER_STEP_EN
  logic step_m_r, step_s_r, step_d_r;

  // Two-flop synchronizer for STEP plus a delay flop for rising-edge detect.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      step_m_r <= 1'b0;
      step_s_r <= 1'b0;
      step_d_r <= 1'b0;
    end else begin
      step_m_r <= STEP;
      step_s_r <= step_m_r;
      step_d_r <= step_s_r;
    end
  end

  // A level held high yields a single-cycle pulse, so nothing is queued.
  assign step_rise_s = step_s_r & ~step_d_r;
`else
  logic unused_step_s;
  assign unused_step_s = STEP;
  assign step_rise_s   = 1'b0;
`endif

  // ------------------------------------------------------------- sequencer
  // pos_r is the position (0..23) inside the MCT currently shown on the
  // outputs; live_r is low when no timepulse is shown (after reset, parked).
  state_t     st_r, st_nx_s;
  logic [4:0] pos_r, pos_nx_s;
  logic       live_r, live_nx_s;

  // Sequencer state register.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      st_r   <= ST_RUN;
      pos_r  <= 5'd0;
      live_r <= 1'b0;
    end else begin
      st_r   <= st_nx_s;
      pos_r  <= pos_nx_s;
      live_r <= live_nx_s;
    end
  end

  // Next-state logic: an MCT in progress always runs to its last cycle;
  // decisions are taken only at the end of T12 or while idle.
  always_comb begin
    st_nx_s   = st_r;
    pos_nx_s  = pos_r;
    live_nx_s = live_r;
    if (live_r) begin
      if (pos_r == LAST_POS) begin
        if (stop_s_r) begin
          st_nx_s   = ST_PARK;
          pos_nx_s  = 5'd0;
          live_nx_s = 1'b0;
        end else begin
          st_nx_s   = ST_RUN;
          pos_nx_s  = 5'd0;
          live_nx_s = 1'b1;
        end
      end else begin
        pos_nx_s = pos_r + 5'd1;
      end
    end else begin
      case (st_r)
        ST_PARK: begin
          // STOP release wins over a simultaneous STEP edge.
          if (!stop_s_r) begin
            st_nx_s   = ST_RUN;
            pos_nx_s  = 5'd0;
            live_nx_s = 1'b1;
          end else if (step_rise_s) begin
            st_nx_s   = ST_STEP1;
            pos_nx_s  = 5'd0;
            live_nx_s = 1'b1;
          end else begin
            st_nx_s   = ST_PARK;
            pos_nx_s  = 5'd0;
            live_nx_s = 1'b0;
          end
        end
        default: begin
          // Idle in RUN only happens right after reset: start T01 at once.
          st_nx_s   = ST_RUN;
          pos_nx_s  = 5'd0;
          live_nx_s = 1'b1;
        end
      endcase
    end
  end

  // ----------------------------------------------------------------- outputs
  logic [11:0] t_nx_s, t_r;
  logic        phs2_nx_s, phs4_nx_s, mct_nx_s, stopped_nx_s;
  logic        phs2_r, phs4_r, mct_r, stopped_r;

  // Output decode from the next state so that the outputs are registered.
  always_comb begin
    t_nx_s       = 12'd0;
    phs2_nx_s    = 1'b0;
    phs4_nx_s    = 1'b0;
    mct_nx_s     = 1'b0;
    stopped_nx_s = (st_nx_s == ST_PARK);
    if (live_nx_s) begin
      t_nx_s    = 12'd1 << pos_nx_s[4:1];
      phs2_nx_s = ~pos_nx_s[0];
      phs4_nx_s = pos_nx_s[0];
      mct_nx_s  = (pos_nx_s == LAST_POS);
    end else begin
      t_nx_s = 12'd0;
    end
  end

  // Output registers.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      t_r       <= 12'd0;
      phs2_r    <= 1'b0;
      phs4_r    <= 1'b0;
      mct_r     <= 1'b0;
      stopped_r <= 1'b0;
    end else begin
      t_r       <= t_nx_s;
      phs2_r    <= phs2_nx_s;
      phs4_r    <= phs4_nx_s;
      mct_r     <= mct_nx_s;
      stopped_r <= stopped_nx_s;
    end
  end

  // --------------------------------------------------------------- divider
  logic [DW-1:0] div_r;
  logic          fs_r;

  // FS01_ divider: free-running in every state, toggles every HALF cycles.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      div_r <= '0;
      fs_r  <= 1'b1;
    end else if (div_r == DIV_TC) begin
      div_r <= '0;
      fs_r  <= ~fs_r;
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  assign FS01_   = fs_r;
  assign T01     = t_r[0];
  assign T02     = t_r[1];
  assign T03     = t_r[2];
  assign T04     = t_r[3];
  assign T05     = t_r[4];
  assign T06     = t_r[5];
  assign T07     = t_r[6];
  assign T08     = t_r[7];
  assign T09     = t_r[8];
  assign T10     = t_r[9];
  assign T11     = t_r[10];
  assign T12     = t_r[11];
  assign PHS2    = phs2_r;
  assign PHS4    = phs4_r;
  assign MCT     = mct_r;
  assign STOPPED = stopped_r;

endmodule

// File: tb/tb_timer_pulse_gen.sv
// Self-checking bench for timer_pulse_gen. Expected output vectors are
// queued as stimulus is applied and compared as each CLOCK edge produces
// DUT output. FS01_ is predicted from the number of edges since reset.
module tb_timer_pulse_gen;

  localparam int DIV  = 20;
  localparam int HALF = DIV / 2;

  typedef struct packed {
    logic [11:0] t;
    logic        phs2;
    logic        phs4;
    logic        mct;
    logic        stopped;
  } vec_t;

  logic CLOCK = 1'b0;
  logic rst   = 1'b0;
  logic STOP  = 1'b0;
  logic STEP  = 1'b0;
  logic FS01_, T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12;
  logic PHS2, PHS4, MCT, STOPPED;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   nxt_pos  = 0;
  vec_t sbq[$];
  vec_t obs, want;

  timer_pulse_gen #(.GATE_DELAY(0), .DIV_FS01(DIV)) dut (
    .CLOCK(CLOCK), .rst(rst), .STOP(STOP), .STEP(STEP), .FS01_(FS01_),
    .T01(T01), .T02(T02), .T03(T03), .T04(T04), .T05(T05), .T06(T06),
    .T07(T07), .T08(T08), .T09(T09), .T10(T10), .T11(T11), .T12(T12),
    .PHS2(PHS2), .PHS4(PHS4), .MCT(MCT), .STOPPED(STOPPED)
  );

  always #5 CLOCK = ~CLOCK;

  // Edges since reset release; edge 1 is cycle 1.
  always @(posedge CLOCK or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic vec_t slot_v(input int p);
    vec_t v;
    v = '0;
    v.t[p / 2] = 1'b1;
    v.phs2 = (p % 2 == 0);
    v.phs4 = (p % 2 == 1);
    v.mct  = (p == 23);
    return v;
  endfunction

  function automatic vec_t park_v();
    vec_t v;
    v = '0;
    v.stopped = 1'b1;
    return v;
  endfunction

  function automatic logic fs_exp(input int c);
    return ((c / HALF) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic push_slot();
    sbq.push_back(slot_v(nxt_pos));
    nxt_pos = (nxt_pos + 1) % 24;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
    obs.t       = {T12, T11, T10, T09, T08, T07, T06, T05, T04, T03, T02, T01};
    obs.phs2    = PHS2;
    obs.phs4    = PHS4;
    obs.mct     = MCT;
    obs.stopped = STOPPED;
    if (sbq.size() > 0) want = sbq.pop_front();
    else                want = 'x;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(vec_t'(0));
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL reset_vec: got %h expected %h", obs, want);
      end
      n_checks++;
      if (FS01_ !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_fs01: got %b expected 1", FS01_);
      end
      n_checks++;
    end
  endtask

  task automatic test_run_fs01();
    logic prev_fs;
    int   first_fall, edges;
    first_fall = -1;
    edges      = 0;
    prev_fs    = 1'b1;
    @(negedge CLOCK);
    rst     = 1'b1;
    nxt_pos = 0;
    for (int c = 1; c <= 200; c++) begin
      push_slot();
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL run_vec cyc%0d: got %h expected %h", cyc, obs, want);
      end
      n_checks++;
      if (FS01_ !== fs_exp(cyc)) begin
        n_fail++;
        $display("FAIL run_fs01 cyc%0d: got %b expected %b", cyc, FS01_, fs_exp(cyc));
      end
      n_checks++;
      if (prev_fs === 1'b1 && FS01_ === 1'b0 && first_fall < 0) first_fall = c;
      if (c > 100 && FS01_ !== prev_fs) edges++;
      prev_fs = FS01_;
    end
    if (first_fall !== HALF) begin
      n_fail++;
      $display("FAIL fs01_first_fall: got cycle %0d expected %0d", first_fall, HALF);
    end
    n_checks++;
    if (edges !== 10) begin
      n_fail++;
      $display("FAIL fs01_edges_per_100: got %0d expected 10", edges);
    end
    n_checks++;
  endtask

  task automatic test_stop();
    // run up to the first cycle of T05, then request STOP
    for (int i = 0; i < 24; i++) begin
      int p;
      p = nxt_pos;
      push_slot();
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL stop_pre cyc%0d: got %h expected %h", cyc, obs, want);
      end
      n_checks++;
      if (p == 8) break;
    end
    STOP = 1'b1;
    // the started MCT completes through T12
    while (nxt_pos != 0) begin
      push_slot();
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL stop_finish cyc%0d: got %h expected %h", cyc, obs, want);
      end
      n_checks++;
    end
    for (int i = 0; i < 8; i++) begin
      sbq.push_back(park_v());
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL stop_park cyc%0d: got %h expected %h", cyc, obs, want);
      end
      n_checks++;
      if (FS01_ !== fs_exp(cyc)) begin
        n_fail++;
        $display("FAIL stop_fs01 cyc%0d: got %b expected %b", cyc, FS01_, fs_exp(cyc));
      end
      n_checks++;
    end
    // release: two synchronizer cycles still parked, then T01
    STOP = 1'b0;
    sbq.push_back(park_v());
    sbq.push_back(park_v());
    nxt_pos = 0;
    for (int i = 0; i < 28; i++) push_slot();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL stop_resume cyc%0d: got %h expected %h", cyc, obs, want);
      end
      n_checks++;
    end
  endtask

  task automatic test_step();
    // park from mid-MCT (nxt_pos is 4 here)
    STOP = 1'b1;
    while (nxt_pos != 0) push_slot();
    for (int i = 0; i < 5; i++) sbq.push_back(park_v());
    while (sbq.size() > 0) begin
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL step_enter_park cyc%0d: got %h expected %h", cyc, obs, want);
      end
      n_checks++;
    end
`ifdef TIMER_STEP_EN
    // STEP high for 3 cycles: two synchronizer cycles parked, then one MCT
    STEP = 1'b1;
    sbq.push_back(park_v());
    sbq.push_back(park_v());
    nxt_pos = 0;
    for (int i = 0; i < 24; i++) push_slot();
    for (int i = 0; i < 6; i++) sbq.push_back(park_v());
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 2)  STEP = 1'b0;
      if (i == 12) STEP = 1'b1;   // second edge mid-MCT must be ignored
      if (i == 14) STEP = 1'b0;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL step_one_mct i%0d: got %h expected %h", i, obs, want);
      end
      n_checks++;
    end
`else
    // STEP has no effect without the step feature
    for (int i = 0; i < 14; i++) sbq.push_back(park_v());
    for (int i = 0; i < 14; i++) begin
      if (i == 0 || i == 6) STEP = 1'b1;
      if (i == 3 || i == 9) STEP = 1'b0;
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL step_ignored i%0d: got %h expected %h", i, obs, want);
      end
      n_checks++;
    end
`endif
    STOP = 1'b0;
    sbq.push_back(park_v());
    sbq.push_back(park_v());
    nxt_pos = 0;
    for (int i = 0; i < 4; i++) push_slot();
    while (sbq.size() > 0) begin
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL step_release cyc%0d: got %h expected %h", cyc, obs, want);
      end
      n_checks++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 24; i++) begin
      int p;
      p = nxt_pos;
      push_slot();
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL rmid_pre cyc%0d: got %h expected %h", cyc, obs, want);
      end
      n_checks++;
      if (p == 13) break;   // T07 with PHS4
    end
    #1;
    rst = 1'b0;
    #1;
    obs.t       = {T12, T11, T10, T09, T08, T07, T06, T05, T04, T03, T02, T01};
    obs.phs2    = PHS2;
    obs.phs4    = PHS4;
    obs.mct     = MCT;
    obs.stopped = STOPPED;
    if (obs !== vec_t'(0) || FS01_ !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_async: got %h fs %b expected 0000 fs 1", obs, FS01_);
    end
    n_checks++;
    @(negedge CLOCK);
    @(negedge CLOCK);
    rst     = 1'b1;
    nxt_pos = 0;
    for (int i = 0; i < 26; i++) begin
      push_slot();
      tick();
      if (obs !== want) begin
        n_fail++;
        $display("FAIL rmid_restart cyc%0d: got %h expected %h", cyc, obs, want);
      end
      n_checks++;
      if (FS01_ !== fs_exp(cyc)) begin
        n_fail++;
        $display("FAIL rmid_fs01 cyc%0d: got %b expected %b", cyc, FS01_, fs_exp(cyc));
      end
      n_checks++;
    end
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    n_checks++;
  endtask

  initial begin
    rst  = 1'b0;
    STOP = 1'b0;
    STEP = 1'b0;
    test_reset();
    test_run_fs01();
    test_stop();
    test_step();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
